// File: rtl/sincos_cordic.sv
// Iterative rotation-mode CORDIC producing sin(q) and cos(q) in signed fixed point.
// One micro-rotation per clock; the angle is clamped to +/-pi and folded into +/-pi/2 first.
module sincos_cordic #(
    parameter int WIDTH        = 32,
    parameter int DECIMAL_BITS = 16,
    parameter int ITERATIONS   = 16
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic signed [WIDTH-1:0] q_in,
    input  logic                    valid_in,
    output logic                    ready_out,
    output logic signed [WIDTH-1:0] sinq_out,
    output logic signed [WIDTH-1:0] cosq_out,
    output logic                    valid_out,
    input  logic                    ready_in
);

    // Constants are given in Q16.16 and rescaled if a different fraction width is chosen.
    function automatic longint scale(input longint c);
        if (DECIMAL_BITS >= 16) return c <<< (DECIMAL_BITS - 16);
        else                    return c >>> (16 - DECIMAL_BITS);
    endfunction

    localparam logic signed [WIDTH-1:0] C_PI   = WIDTH'(scale(205887));
    localparam logic signed [WIDTH-1:0] C_PI_2 = WIDTH'(scale(102944));
    localparam logic signed [WIDTH-1:0] C_K    = WIDTH'(scale(39797));
    localparam logic        [4:0]       C_LAST = 5'(ITERATIONS);

    function automatic logic signed [WIDTH-1:0] atan_lut(input logic [4:0] i);
        longint a;
        case (i)
            5'd0:    a = 51472;
            5'd1:    a = 30386;
            5'd2:    a = 16055;
            5'd3:    a = 8150;
            5'd4:    a = 4091;
            5'd5:    a = 2047;
            5'd6:    a = 1024;
            5'd7:    a = 512;
            5'd8:    a = 256;
            5'd9:    a = 128;
            5'd10:   a = 64;
            5'd11:   a = 32;
            5'd12:   a = 16;
            5'd13:   a = 8;
            5'd14:   a = 4;
            5'd15:   a = 2;
            default: a = 0;
        endcase
        return WIDTH'(scale(a));
    endfunction

    typedef enum logic [1:0] {IDLE, ROTATE, DONE} state_t;

    state_t                  r_state;
    logic signed [WIDTH-1:0] r_x, r_y, r_z;
    logic        [4:0]       r_cnt;
    logic                    r_neg;

    logic signed [WIDTH-1:0] w_q_clamp, w_z0;
    logic                    w_neg0;
    logic signed [WIDTH-1:0] w_xsh, w_ysh, w_atan;
    logic signed [WIDTH-1:0] w_x_nxt, w_y_nxt, w_z_nxt;

    // Clamp to +/-pi, then fold the outer quadrants through pi so z0 stays within the CORDIC range.
    always_comb begin
        w_q_clamp = q_in;
        if (q_in > C_PI)       w_q_clamp = C_PI;
        else if (q_in < -C_PI) w_q_clamp = -C_PI;

        w_z0   = w_q_clamp;
        w_neg0 = 1'b0;
        if (w_q_clamp > C_PI_2) begin
            w_z0   = w_q_clamp - C_PI;
            w_neg0 = 1'b1;
        end else if (w_q_clamp < -C_PI_2) begin
            w_z0   = w_q_clamp + C_PI;
            w_neg0 = 1'b1;
        end
    end

    always_comb begin
        w_xsh  = r_x >>> r_cnt;
        w_ysh  = r_y >>> r_cnt;
        w_atan = atan_lut(r_cnt);
        if (!r_z[WIDTH-1]) begin
            w_x_nxt = r_x - w_ysh;
            w_y_nxt = r_y + w_xsh;
            w_z_nxt = r_z - w_atan;
        end else begin
            w_x_nxt = r_x + w_ysh;
            w_y_nxt = r_y - w_xsh;
            w_z_nxt = r_z + w_atan;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state   <= IDLE;
            r_x       <= '0;
            r_y       <= '0;
            r_z       <= '0;
            r_cnt     <= '0;
            r_neg     <= 1'b0;
            sinq_out  <= '0;
            cosq_out  <= '0;
            valid_out <= 1'b0;
            ready_out <= 1'b1;
        end else begin
            case (r_state)
                IDLE: begin
                    if (valid_in) begin
                        r_x       <= C_K;
                        r_y       <= '0;
                        r_z       <= w_z0;
                        r_neg     <= w_neg0;
                        r_cnt     <= '0;
                        ready_out <= 1'b0;
                        r_state   <= ROTATE;
                    end
                end
                ROTATE: begin
                    // The cycle after the last micro-rotation publishes the result.
                    if (r_cnt == C_LAST) begin
                        sinq_out  <= r_neg ? -r_y : r_y;
                        cosq_out  <= r_neg ? -r_x : r_x;
                        valid_out <= 1'b1;
                        r_state   <= DONE;
                    end else begin
                        r_x   <= w_x_nxt;
                        r_y   <= w_y_nxt;
                        r_z   <= w_z_nxt;
                        r_cnt <= r_cnt + 5'd1;
                    end
                end
                DONE: begin
                    if (ready_in) begin
                        valid_out <= 1'b0;
                        ready_out <= 1'b1;
                        r_state   <= IDLE;
                    end
                end
                default: begin
                    valid_out <= 1'b0;
                    ready_out <= 1'b1;
                    r_state   <= IDLE;
                end
            endcase
        end
    end

endmodule
